// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared sizes, FSM states and arithmetic helpers for the spiking step scheduler
// Contents: default sizes (DEF_N_IN, DEF_N_OUT, DEF_W), state_t, w_index(), sat_add(), sat_sub().
package snn_pkg;

  localparam int DEF_N_IN  = 4;
  localparam int DEF_N_OUT = 3;
  localparam int DEF_W     = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAK,
    S_ACC,
    S_FIRE,
    S_DONE
  } state_t;

  // Flat weight-store index for synapse (input i -> neuron n).
  function automatic int unsigned w_index(input int unsigned i, input int unsigned n,
                                          input int unsigned n_out);
    return i * n_out + n;
  endfunction

  // Unsigned add that clamps at all-ones instead of wrapping.
  function automatic logic [DEF_W-1:0] sat_add(input logic [DEF_W-1:0] a,
                                               input logic [DEF_W-1:0] b);
    logic [DEF_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DEF_W] ? {DEF_W{1'b1}} : s[DEF_W-1:0];
  endfunction

  // Unsigned subtract that clamps at zero instead of wrapping.
  function automatic logic [DEF_W-1:0] sat_sub(input logic [DEF_W-1:0] a,
                                               input logic [DEF_W-1:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction

endpackage

// File: rtl/snn_neuron_state_bank.sv
// rtl/snn_neuron_state_bank.sv - per-neuron membrane potential and refractory counter storage
// Ports: clk, clr (synchronous clear of every entry), idx (neuron select for both read and write),
//        we/wr_pot/wr_refr (write port), rd_pot/rd_refr (combinational read of entry idx).
module snn_neuron_state_bank
  import snn_pkg::*;
#(
  parameter int N_OUT = DEF_N_OUT,
  parameter int W     = DEF_W,
  parameter int NW    = 2
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [NW-1:0] idx,
  input  logic          we,
  input  logic [W-1:0]  wr_pot,
  input  logic [W-1:0]  wr_refr,
  output logic [W-1:0]  rd_pot,
  output logic [W-1:0]  rd_refr
);

  logic [W-1:0] pot_q  [N_OUT];
  logic [W-1:0] refr_q [N_OUT];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < N_OUT; i++) begin
        pot_q[i]  <= '0;
        refr_q[i] <= '0;
      end
    end else if (we) begin
      pot_q[idx]  <= wr_pot;
      refr_q[idx] <= wr_refr;
    end
  end

  assign rd_pot  = pot_q[idx];
  assign rd_refr = refr_q[idx];

endmodule

// File: rtl/snn_step_scheduler.sv
// rtl/snn_step_scheduler.sv - time-multiplexed leaky-integrate-and-fire timestep scheduler
// Ports: clk, rst_n (sync, active-low); tick/input_spikes start a step; threshold/leak_rate/
//        refractory are shadowed on the accepted tick; w_addr/w_data read the weight store with
//        one cycle latency; output_spikes/step_done report the finished step; busy, overrun
//        (sticky, cleared by overrun_clr).
module snn_step_scheduler
  import snn_pkg::*;
#(
  parameter int N_IN  = DEF_N_IN,
  parameter int N_OUT = DEF_N_OUT,
  parameter int W     = DEF_W,
  localparam int WA   = $clog2(N_IN * N_OUT),
  localparam int NW   = (N_OUT > 1) ? $clog2(N_OUT) : 1,
  localparam int CW   = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic [N_IN-1:0]  input_spikes,
  input  logic [W-1:0]     threshold,
  input  logic [W-1:0]     leak_rate,
  input  logic [W-1:0]     refractory,
  output logic [WA-1:0]    w_addr,
  input  logic [W-1:0]     w_data,
  output logic [N_OUT-1:0] output_spikes,
  output logic             step_done,
  output logic             busy,
  output logic             overrun,
  input  logic             overrun_clr
);

  state_t          state_q, state_d;
  logic [NW-1:0]   n_q;
  logic [CW-1:0]   c_q;
  logic [W-1:0]    acc_q;
  logic [W-1:0]    thr_q, leak_q, refr_cfg_q;
  logic [N_IN-1:0] in_q;
  logic [N_OUT-1:0] spk_q;

  logic [W-1:0] rd_pot, rd_refr, wr_pot, wr_refr;
  logic         bank_we, fire_now;
  logic         accept, last_n, last_c, tick_drop;

  // The IDLE cycle that carries step_done still belongs to the previous step.
  assign accept    = (state_q == S_IDLE) && tick && !step_done;
  assign tick_drop = tick && ((state_q != S_IDLE) || step_done);
  assign last_n    = (n_q == NW'(N_OUT - 1));
  assign last_c    = (c_q == CW'(N_IN - 1));

  snn_neuron_state_bank #(.N_OUT(N_OUT), .W(W), .NW(NW)) u_bank (
    .clk     (clk),
    .clr     (!rst_n),
    .idx     (n_q),
    .we      (bank_we),
    .wr_pot  (wr_pot),
    .wr_refr (wr_refr),
    .rd_pot  (rd_pot),
    .rd_refr (rd_refr)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    bank_we  = 1'b0;
    fire_now = 1'b0;
    wr_pot   = acc_q;
    wr_refr  = '0;
    unique case (state_q)
      S_IDLE: if (accept) state_d = S_LEAK;
      S_LEAK: state_d = S_ACC;
      S_ACC:  if (last_c) state_d = S_FIRE;
      S_FIRE: begin
        bank_we = 1'b1;
        if (rd_refr != '0) begin
          // Refractory: the accumulated value is thrown away.
          wr_pot  = '0;
          wr_refr = rd_refr - 1'b1;
        end else if (acc_q >= thr_q) begin
          fire_now = 1'b1;
          wr_pot   = '0;
          wr_refr  = refr_cfg_q;
        end
        state_d = last_n ? S_DONE : S_LEAK;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      n_q           <= '0;
      c_q           <= '0;
      acc_q         <= '0;
      thr_q         <= '0;
      leak_q        <= '0;
      refr_cfg_q    <= '0;
      in_q          <= '0;
      spk_q         <= '0;
      w_addr        <= '0;
      output_spikes <= '0;
      step_done     <= 1'b0;
      busy          <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      step_done <= 1'b0;
      if (tick_drop)        overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;

      unique case (state_q)
        S_IDLE: if (accept) begin
          in_q       <= input_spikes;
          thr_q      <= threshold;
          leak_q     <= leak_rate;
          refr_cfg_q <= refractory;
          n_q        <= '0;
          spk_q      <= '0;
          busy       <= 1'b1;
        end
        S_LEAK: begin
          acc_q  <= sat_sub(rd_pot, leak_q);
          w_addr <= WA'(w_index(0, int'(n_q), N_OUT));
          c_q    <= '0;
        end
        S_ACC: begin
          // w_data here belongs to input c_q; prefetch the next input's weight.
          if (in_q[c_q]) acc_q <= sat_add(acc_q, w_data);
          if (!last_c) begin
            w_addr <= WA'(w_index(int'(c_q) + 1, int'(n_q), N_OUT));
            c_q    <= c_q + 1'b1;
          end
        end
        S_FIRE: begin
          spk_q[n_q] <= fire_now;
          if (!last_n) n_q <= n_q + 1'b1;
        end
        S_DONE: begin
          output_spikes <= spk_q;
          step_done     <= 1'b1;
          busy          <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
